micro_reg_file_mp: RTL and testbench
====================================

# micro_reg_file_mp

Parametrised multi-port successor to the single-port micro register file. It provides one synchronous write port and two independent registered read ports, with write-first bypass. A built-in clear sequencer zeroes every entry after reset or on request. It sits between the micro-decode register stage and the ALU, supplying both source operands in one cycle instead of through the EXECUTE1/EXECUTE2 two-phase access.

## Interface
Parameters:
- DATA_WIDTH, 16, bits per entry
- DEPTH, 16, number of entries; need not be a power of two
- ADDR_WIDTH, $clog2(DEPTH) (minimum 1), width of every address port

Ports:
- sys_clk  in  1  single clock; all state updates on its rising edge
- sys_reset_n  in  1  synchronous, active-low reset
- clr_req  in  1  single-cycle request to zero the whole file
- busy  out  1  high while the clear sequencer runs
- wr_en  in  1  write enable
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- rd_en_a, rd_en_b  in  1  read enables, port A / port B
- rd_addr_a, rd_addr_b  in  ADDR_WIDTH  read addresses
- rd_data_a, rd_data_b  out  DATA_WIDTH  registered read data
- rd_valid_a, rd_valid_b  out  1  one-cycle pulse qualifying rd_data_x
- addr_err  out  1  one-cycle pulse: an enabled access used an address >= DEPTH

## Operation
- FSM states:
  - CLEAR: writes 0 to entry clr_ptr, clr_ptr++ each cycle; busy=1.
  - IDLE: normal access; busy=0.
- Transitions:
  - Reset → CLEAR with clr_ptr=0.
  - CLEAR → IDLE on the cycle after clr_ptr==DEPTH-1 is written.
  - IDLE → CLEAR when clr_req=1 (clr_ptr=0).
  - clr_req while in CLEAR is ignored; the clear does not restart.
- While busy=1:
  - wr_en, rd_en_a and rd_en_b are ignored.
  - rd_valid_x stays 0 and addr_err stays 0.
  - rd_data_x hold their values.
- Write in IDLE: if wr_en=1 and wr_addr<DEPTH, the entry is updated at the clock edge.
- Write with wr_addr>=DEPTH: dropped, and addr_err pulses.
- Read in IDLE: if rd_en_x=1, the data is registered into rd_data_x and rd_valid_x=1 on the next cycle.
  - rd_addr_x>=DEPTH: rd_data_x loads 0, rd_valid_x=1, addr_err pulses.
- Bypass (write-first): if wr_en=1, rd_en_x=1 and rd_addr_x==wr_addr (in range) in the same cycle, rd_data_x gets wr_data rather than the stale entry. This applies to each port independently; both ports may bypass the same write.
- Ports A and B may read the same address in the same cycle; both return identical data.
- When rd_en_x=0, rd_data_x holds its previous value and rd_valid_x=0.
- addr_err is the OR of all three port errors, registered and asserted for one cycle.

## Timing
- Reset values (while sys_reset_n=0 and on the first cycle after):
  - rd_data_a, rd_data_b = 0
  - rd_valid_a, rd_valid_b = 0
  - addr_err = 0
  - busy = 1
  - clr_ptr = 0
- Array contents are not directly reset; the sequencer zeroes them.
- Clear latency: busy stays high for exactly DEPTH cycles after sys_reset_n rises or after the clr_req edge. The first access is accepted on the cycle busy reads 0.
- Read latency: 1 cycle, from rd_en_x sampled at edge N to rd_data_x/rd_valid_x valid after edge N+1. Full throughput: one read per port per cycle.
- Write visibility:
  - A write at edge N is readable via the array from edge N+1 onward.
  - It is visible via bypass for a read issued in the same cycle.
- A reset asserted mid-clear or mid-access aborts everything and restarts CLEAR from entry 0. Pending rd_valid/addr_err pulses are squashed.
- clr_req and wr_en in the same IDLE cycle: the clear wins and the write is dropped.
- clr_req and rd_en_x in the same IDLE cycle: the read completes normally one cycle later, then busy asserts.

## Test plan
- Reset then idle: release sys_reset_n → busy=1 for exactly DEPTH(16) cycles. Then read every address on both ports → all 0, rd_valid pulses each cycle.
- Write/read: write 0xBEEF to addr 3, next cycle read A=3, B=3 → both return 0xBEEF with rd_valid_a=rd_valid_b=1 one cycle later.
- Bypass: same cycle wr_en addr 5 data 0x1234, rd_en_a addr 5, rd_en_b addr 6 (holding 0x00AA) → rd_data_a=0x1234, rd_data_b=0x00AA.
- Out-of-range (DEPTH=12): write addr 13 → addr_err pulses and no entry changes. Read addr 14 → rd_data=0, rd_valid=1, addr_err=1.
- Runtime clear: fill all entries with nonzero values, pulse clr_req with a simultaneous wr_en → the write is dropped, busy high for DEPTH cycles, accesses during busy are ignored, all entries read 0 afterwards.
- Reset mid-clear: assert sys_reset_n=0 at clr_ptr=7 for 1 cycle → busy restarts and lasts a full DEPTH cycles from release; no stray rd_valid.

Source files
------------

// File: rtl/micro_reg_file_mp.sv
// Multi-port micro register file: one synchronous write port, two registered read
// ports with write-first bypass, and a sequencer that zeroes the array after reset or on request.
module micro_reg_file_mp #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_reset_n,
    input  logic                  clr_req,
    output logic                  busy,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic                  rd_en_b,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  rd_valid_a,
    output logic                  rd_valid_b,
    output logic                  addr_err
);

    // state    | meaning
    // ST_CLEAR | zero entry clr_ptr each cycle, accesses ignored, busy=1
    // ST_IDLE  | normal read/write access, busy=0
    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] clr_ptr, clr_ptr_nxt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  idle;
    logic                  wr_ok, rd_ok_a, rd_ok_b;
    logic                  wr_fire;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] rd_word_a, rd_word_b;

    assign idle    = (state == ST_IDLE);
    assign busy    = ~idle;
    assign wr_ok   = {1'b0, wr_addr}   < DEPTH_EXT;
    assign rd_ok_a = {1'b0, rd_addr_a} < DEPTH_EXT;
    assign rd_ok_b = {1'b0, rd_addr_b} < DEPTH_EXT;
    // A clear request in the same cycle takes priority, so the write never lands.
    assign wr_fire = idle & wr_en & wr_ok & ~clr_req;

    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        case (state)
            ST_CLEAR: begin
                if (clr_ptr == LAST_PTR) begin
                    state_nxt   = ST_IDLE;
                    clr_ptr_nxt = '0;
                end else begin
                    clr_ptr_nxt = clr_ptr + ADDR_WIDTH'(1);
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    state_nxt   = ST_CLEAR;
                    clr_ptr_nxt = '0;
                end
            end
            default: begin
                state_nxt   = ST_CLEAR;
                clr_ptr_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_reset_n) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (!idle) begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr;
            mem_wdata = '0;
        end else if (wr_fire) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset_n && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        rd_word_a = '0;
        rd_word_b = '0;
        if (rd_ok_a) begin
            rd_word_a = (wr_fire && (wr_addr == rd_addr_a)) ? wr_data : mem[rd_addr_a];
        end
        if (rd_ok_b) begin
            rd_word_b = (wr_fire && (wr_addr == rd_addr_b)) ? wr_data : mem[rd_addr_b];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_reset_n) begin
            rd_data_a  <= '0;
            rd_data_b  <= '0;
            rd_valid_a <= 1'b0;
            rd_valid_b <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            rd_valid_a <= idle & rd_en_a;
            rd_valid_b <= idle & rd_en_b;
            addr_err   <= idle & ((wr_en & ~wr_ok) | (rd_en_a & ~rd_ok_a) | (rd_en_b & ~rd_ok_b));
            if (idle && rd_en_a) begin
                rd_data_a <= rd_word_a;
            end
            if (idle && rd_en_b) begin
                rd_data_b <= rd_word_b;
            end
        end
    end

endmodule

// File: tb/tb_micro_reg_file_mp.sv
// Bench for micro_reg_file_mp at DEPTH=12: behavioural array model compared every cycle,
// plus directed vectors with literal expectations.
module tb_micro_reg_file_mp;

    localparam int DW    = 16;
    localparam int DEPTH = 12;
    localparam int AW    = 4;

    logic          sys_clk     = 1'b0;
    logic          sys_reset_n = 1'b0;
    logic          clr_req     = 1'b0;
    logic          wr_en       = 1'b0;
    logic [AW-1:0] wr_addr     = '0;
    logic [DW-1:0] wr_data     = '0;
    logic          rd_en_a     = 1'b0;
    logic [AW-1:0] rd_addr_a   = '0;
    logic          rd_en_b     = 1'b0;
    logic [AW-1:0] rd_addr_b   = '0;
    logic          busy, rd_valid_a, rd_valid_b, addr_err;
    logic [DW-1:0] rd_data_a, rd_data_b;

    int checks = 0;
    int errors = 0;
    bit check_on = 1'b0;

    always #5 sys_clk = ~sys_clk;

    micro_reg_file_mp #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .sys_clk    (sys_clk),
        .sys_reset_n(sys_reset_n),
        .clr_req    (clr_req),
        .busy       (busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_en_a    (rd_en_a),
        .rd_addr_a  (rd_addr_a),
        .rd_en_b    (rd_en_b),
        .rd_addr_b  (rd_addr_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .rd_valid_a (rd_valid_a),
        .rd_valid_b (rd_valid_b),
        .addr_err   (addr_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: array of ints, a count of clear cycles still owed, and the expected outputs.
    int m_mem [DEPTH];
    int m_clear_left = DEPTH;
    int m_da = 0;
    int m_db = 0;
    bit m_va = 1'b0;
    bit m_vb = 1'b0;
    bit m_err = 1'b0;
    bit m_take;

    function automatic int model_read(input int a, input bit take);
        if (a >= DEPTH) return 0;
        if (take && a == int'(wr_addr)) return int'(wr_data);
        return m_mem[a];
    endfunction

    always @(posedge sys_clk) begin
        if (!sys_reset_n) begin
            m_clear_left = DEPTH;
            m_va = 1'b0; m_vb = 1'b0; m_err = 1'b0;
            m_da = 0; m_db = 0;
        end else if (m_clear_left > 0) begin
            m_mem[DEPTH - m_clear_left] = 0;
            m_clear_left--;
            m_va = 1'b0; m_vb = 1'b0; m_err = 1'b0;
        end else begin
            m_take = wr_en && (int'(wr_addr) < DEPTH) && !clr_req;
            m_va = rd_en_a;
            m_vb = rd_en_b;
            if (rd_en_a) m_da = model_read(int'(rd_addr_a), m_take);
            if (rd_en_b) m_db = model_read(int'(rd_addr_b), m_take);
            m_err = (wr_en && int'(wr_addr) >= DEPTH) || (rd_en_a && int'(rd_addr_a) >= DEPTH)
                    || (rd_en_b && int'(rd_addr_b) >= DEPTH);
            if (m_take) m_mem[int'(wr_addr)] = int'(wr_data);
            if (clr_req) m_clear_left = DEPTH;
        end
    end

    always @(negedge sys_clk) begin
        if (check_on) begin
            chk("busy",       32'(busy),       32'(m_clear_left != 0));
            chk("rd_valid_a", 32'(rd_valid_a), 32'(m_va));
            chk("rd_valid_b", 32'(rd_valid_b), 32'(m_vb));
            chk("addr_err",   32'(addr_err),   32'(m_err));
            chk("rd_data_a",  32'(rd_data_a),  32'(m_da));
            chk("rd_data_b",  32'(rd_data_b),  32'(m_db));
        end
    end

    task automatic drive(input bit we, input int wa, input int wd, input bit rea, input int ra,
                         input bit reb, input int rb, input bit clr);
        wr_en     = we;
        wr_addr   = AW'(wa);
        wr_data   = DW'(wd);
        rd_en_a   = rea;
        rd_addr_a = AW'(ra);
        rd_en_b   = reb;
        rd_addr_b = AW'(rb);
        clr_req   = clr;
        @(negedge sys_clk);
    endtask

    task automatic zero_inputs();
        wr_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0; clr_req = 1'b0;
    endtask

    // Counts sampled cycles with busy high; optionally hammers the ports meanwhile.
    task automatic busy_phase(output int n, input bit noisy);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (noisy) begin
                wr_en     = 1'b1;
                wr_addr   = AW'($urandom_range(0, DEPTH - 1));
                wr_data   = DW'($urandom);
                rd_en_a   = 1'b1;
                rd_addr_a = AW'($urandom_range(0, 15));
                rd_en_b   = 1'b1;
                rd_addr_b = AW'($urandom_range(0, 15));
                clr_req   = (n == 4);
            end
            @(negedge sys_clk);
        end
        zero_inputs();
    endtask

    int n;

    initial begin
        repeat (2) @(negedge sys_clk);
        check_on = 1'b1;
        chk("reset_busy", 32'(busy), 32'd1);
        chk("reset_rd_data_a", 32'(rd_data_a), 32'd0);
        @(negedge sys_clk);
        sys_reset_n = 1'b1;
        busy_phase(n, 1'b0);
        chk("reset_clear_len", 32'(n), 32'd12);

        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 0, 1, i, 1, DEPTH - 1 - i, 0);
            chk("init_zero_a", 32'(rd_data_a), 32'd0);
            chk("init_valid_b", 32'(rd_valid_b), 32'd1);
        end

        drive(1, 3, 'hBEEF, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 3, 1, 3, 0);
        chk("wr_rd_a", 32'(rd_data_a), 32'h0000_BEEF);
        chk("wr_rd_b", 32'(rd_data_b), 32'h0000_BEEF);
        chk("wr_rd_va", 32'(rd_valid_a), 32'd1);

        drive(1, 6, 'h00AA, 0, 0, 0, 0, 0);
        drive(1, 5, 'h1234, 1, 5, 1, 6, 0);
        chk("bypass_a", 32'(rd_data_a), 32'h0000_1234);
        chk("bypass_b", 32'(rd_data_b), 32'h0000_00AA);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("hold_a", 32'(rd_data_a), 32'h0000_1234);
        chk("hold_va", 32'(rd_valid_a), 32'd0);

        drive(1, 13, 'h5555, 0, 0, 0, 0, 0);
        chk("oor_wr_err", 32'(addr_err), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("err_pulse_end", 32'(addr_err), 32'd0);
        drive(0, 0, 0, 1, 14, 1, 1, 0);
        chk("oor_rd_data", 32'(rd_data_a), 32'd0);
        chk("oor_rd_valid", 32'(rd_valid_a), 32'd1);
        chk("oor_rd_err", 32'(addr_err), 32'd1);
        chk("oor_other_port", 32'(rd_data_b), 32'd0);

        for (int i = 0; i < DEPTH; i++) drive(1, i, 'h1000 + i * 'h111, 0, 0, 0, 0, 0);
        drive(1, 0, 'hDEAD, 1, 2, 0, 0, 1);
        chk("clr_rd_valid", 32'(rd_valid_a), 32'd1);
        chk("clr_rd_data", 32'(rd_data_a), 32'h0000_1222);
        chk("clr_busy", 32'(busy), 32'd1);
        busy_phase(n, 1'b1);
        chk("runtime_clear_len", 32'(n), 32'd12);
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 0, 1, i, 1, i, 0);
            chk("cleared_a", 32'(rd_data_a), 32'd0);
        end

        drive(1, 4, 'h4444, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (7) drive(0, 0, 0, 0, 0, 0, 0, 0);
        sys_reset_n = 1'b0;
        rd_en_a = 1'b1;
        rd_addr_a = AW'(4);
        @(negedge sys_clk);
        chk("midclr_rst_valid", 32'(rd_valid_a), 32'd0);
        rd_en_a = 1'b0;
        sys_reset_n = 1'b1;
        busy_phase(n, 1'b0);
        chk("midclr_clear_len", 32'(n), 32'd12);
        drive(0, 0, 0, 1, 4, 1, 11, 0);
        chk("after_rst_a", 32'(rd_data_a), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
